// File: rtl/lcd_sprite_scheduler.sv
// PCD8544 byte sequencer: power-on init, full clear and 8-column sprite blits
// presented one byte at a time to spi_master through an avail handshake.
`timescale 1ns/1ps
module lcd_sprite_scheduler #(
  parameter logic [7:0] VOP         = 8'h90,
  parameter logic [7:0] BIAS        = 8'h13,
  parameter int         CLEAR_BYTES = 504,
  parameter int         COLS        = 84,
  parameter int         BANKS       = 6
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] spi_data,
  output logic       spi_start,
  output logic       spi_cmd,
  input  logic       spi_avail,
  input  logic       spi_busy,
  input  logic       draw_req,
  input  logic [1:0] sprite_id,
  input  logic [6:0] pos_x,
  input  logic [2:0] pos_bank,
  input  logic       clear_req,
  output logic       ready,
  output logic       done,
  output logic       err,
  output logic       init_done
);

  typedef enum logic [2:0] {
    INIT_CMD, CLR_ADDR, CLR_DATA, IDLE, DRAW_ADDR, DRAW_DATA, DONE
  } state_t;

  state_t     state, nxt_state;
  logic [8:0] cnt, nxt_cnt;
  logic [1:0] id_q, nxt_id;
  logic [6:0] x_q, nxt_x;
  logic [2:0] bank_q, nxt_bank;
  logic       nxt_init_done, nxt_err, nxt_start, nxt_cmd;
  logic [7:0] nxt_data;
  logic       step, last, draw_ok;
  logic [6:0] cols_left;
  logic [3:0] draw_n;

  // Column data for the four sprites, bit 0 is the top pixel of the bank.
  function automatic logic [7:0] sprite_col(input logic [1:0] id, input logic [2:0] col);
    logic [7:0] face [8];
    face = '{8'h3C, 8'h42, 8'hA5, 8'h81, 8'hA5, 8'h99, 8'h42, 8'h3C};
    case (id)
      2'd0:    return face[col];
      2'd1:    return (col == 3'd4) ? 8'h99 : (col == 3'd5) ? 8'hA5 : face[col];
      2'd2:    return 8'h00;
      default: return 8'hFF;
    endcase
  endfunction

  assign ready     = (state == IDLE) & init_done & ~spi_busy;
  assign step      = spi_start & spi_avail;
  assign cols_left = 7'(COLS) - x_q;
  // Clip the blit at the right edge rather than wrapping into the next bank.
  assign draw_n    = (cols_left >= 7'd8) ? 4'd8 : cols_left[3:0];
  assign draw_ok   = (pos_x < 7'(COLS)) && (pos_bank < 3'(BANKS));

  // Last-byte detection for the stream belonging to the current state.
  always_comb begin
    last = 1'b0;
    case (state)
      INIT_CMD:            last = (cnt == 9'd4);
      CLR_ADDR, DRAW_ADDR: last = (cnt == 9'd1);
      CLR_DATA:            last = (cnt == 9'(CLEAR_BYTES - 1));
      DRAW_DATA:           last = (cnt == 9'(draw_n) - 9'd1);
      default:             last = 1'b0;
    endcase
  end

  // Next state, byte index and latched request fields.
  always_comb begin
    nxt_state     = state;
    nxt_cnt       = cnt;
    nxt_id        = id_q;
    nxt_x         = x_q;
    nxt_bank      = bank_q;
    nxt_init_done = init_done;
    nxt_err       = 1'b0;
    if (state == IDLE) begin
      if (ready && clear_req) begin
        nxt_state = CLR_ADDR;
        nxt_cnt   = '0;
      end else if (ready && draw_req) begin
        if (draw_ok) begin
          nxt_state = DRAW_ADDR;
          nxt_cnt   = '0;
          nxt_id    = sprite_id;
          nxt_x     = pos_x;
          nxt_bank  = pos_bank;
        end else begin
          nxt_err = 1'b1;
        end
      end
    end else if (state == DONE) begin
      nxt_state = IDLE;
    end else if (step) begin
      if (!last) begin
        nxt_cnt = cnt + 9'd1;
      end else begin
        nxt_cnt = '0;
        if (state == INIT_CMD)       nxt_state = CLR_ADDR;
        else if (state == CLR_ADDR)  nxt_state = CLR_DATA;
        else if (state == DRAW_ADDR) nxt_state = DRAW_DATA;
        else if (state == DRAW_DATA) nxt_state = DONE;
        else if (init_done)          nxt_state = DONE;
        else begin
          // The power-on clear completes silently and opens the block for requests.
          nxt_state     = IDLE;
          nxt_init_done = 1'b1;
        end
      end
    end
  end

  // Byte that will be presented once the next state is registered.
  always_comb begin
    nxt_start = nxt_state inside {INIT_CMD, CLR_ADDR, CLR_DATA, DRAW_ADDR, DRAW_DATA};
    nxt_cmd   = nxt_state inside {CLR_DATA, DRAW_DATA};
    nxt_data  = 8'h00;
    case (nxt_state)
      INIT_CMD: begin
        case (nxt_cnt[2:0])
          3'd0:    nxt_data = 8'h21;
          3'd1:    nxt_data = VOP;
          3'd2:    nxt_data = BIAS;
          3'd3:    nxt_data = 8'h20;
          default: nxt_data = 8'h0C;
        endcase
      end
      CLR_ADDR:  nxt_data = (nxt_cnt == 9'd0) ? 8'h80 : 8'h40;
      DRAW_ADDR: nxt_data = (nxt_cnt == 9'd0) ? {1'b1, nxt_x} : {5'b01000, nxt_bank};
      DRAW_DATA: nxt_data = sprite_col(nxt_id, nxt_cnt[2:0]);
      default:   nxt_data = 8'h00;
    endcase
  end

  // State and registered outputs; reset drops everything and restarts init.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= INIT_CMD;
      cnt       <= '0;
      id_q      <= '0;
      x_q       <= '0;
      bank_q    <= '0;
      spi_data  <= '0;
      spi_start <= 1'b0;
      spi_cmd   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      id_q      <= nxt_id;
      x_q       <= nxt_x;
      bank_q    <= nxt_bank;
      spi_data  <= nxt_data;
      spi_start <= nxt_start;
      spi_cmd   <= nxt_cmd;
      done      <= (nxt_state == DONE);
      err       <= nxt_err;
      init_done <= nxt_init_done;
    end
  end

endmodule
